// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM port that
// mem_arbiter sits between. The slave modport is the arbiter's view; the
// master modport is the core + RAM side.
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_we, mem_a, mem_wd
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported 32-bit RAM between the instruction fetch (I) and
// load/store (D) requesters. One transaction at a time:
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a request; grant is combinational from req
//   ACCESS | latched address/data on the RAM; wait counter runs down,
//          | write strobe and read capture happen on its last cycle
//   RESP   | owner's rvalid pulses for this single cycle
//
// Response data lives in one register per owner so a fetch result is not
// disturbed by an intervening load/store and vice versa.
module mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter bit          RR_ENABLE   = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic       OWN_I     = 1'b0;
   localparam logic       OWN_D     = 1'b1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        i_rvalid_q, i_rvalid_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic        mem_we_q, mem_we_d;
   logic        grant_i, grant_d;

   // Arbitration and next-state computation. mem_we is precomputed one cycle
   // ahead so it is a flop output that is high exactly on the final ACCESS cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_rvalid_d   = 1'b0;
      d_rvalid_d   = 1'b0;
      mem_we_d     = 1'b0;
      grant_i      = 1'b0;
      grant_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.i_req && bus.d_req) begin
               // Round-robin hands the conflict to whoever did not go last.
               if (RR_ENABLE && (last_owner_q == OWN_D)) grant_i = 1'b1;
               else                                      grant_d = 1'b1;
            end else if (bus.i_req) begin
               grant_i = 1'b1;
            end else if (bus.d_req) begin
               grant_d = 1'b1;
            end

            if (grant_i) begin
               addr_d       = bus.i_addr;
               wdata_d      = '0;
               we_d         = 1'b0;
               owner_d      = OWN_I;
               last_owner_d = OWN_I;
               cnt_d        = WAIT_INIT;
               state_d      = ACCESS;
            end else if (grant_d) begin
               addr_d       = bus.d_addr;
               wdata_d      = bus.d_wdata;
               we_d         = bus.d_we;
               owner_d      = OWN_D;
               last_owner_d = OWN_D;
               cnt_d        = WAIT_INIT;
               state_d      = ACCESS;
               mem_we_d     = (WAIT_INIT == 4'd0) && bus.d_we;
            end
         end

         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d    = cnt_q - 4'd1;
               mem_we_d = (cnt_q == 4'd1) && we_q;
            end else begin
               // Read data is captured on the same edge the write lands, so a
               // store returns the word it replaced.
               if (owner_q == OWN_D) begin
                  d_rdata_d  = bus.mem_rd;
                  d_rvalid_d = 1'b1;
               end else begin
                  i_rdata_d  = bus.mem_rd;
                  i_rvalid_d = 1'b1;
               end
               state_d = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All arbiter state; reset leaves last_owner at D so I wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_D;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_rvalid_q   <= 1'b0;
         d_rvalid_q   <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_rvalid_q   <= i_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         mem_we_q     <= mem_we_d;
      end
   end

   // Grants are the only combinational outputs; held low while in reset.
   assign bus.i_gnt    = grant_i & reset_n;
   assign bus.d_gnt    = grant_d & reset_n;
   assign bus.i_rvalid = i_rvalid_q;
   assign bus.i_rdata  = i_rdata_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_a    = addr_q;
   assign bus.mem_wd   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances with different parameters, each with
// its own small RAM model, exercised with a vector table and directed sequences.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic rst3_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bus0 ();   // WAIT=0, round-robin
   mem_arbiter_if bus1 ();   // WAIT=0, fixed priority
   mem_arbiter_if bus2 ();   // WAIT=3, round-robin
   mem_arbiter_if bus3 ();   // WAIT=2, round-robin, own reset

   mem_arbiter #(.WAIT_CYCLES(0), .RR_ENABLE(1'b1)) u0 (.clk(clk), .reset_n(rst_n),  .bus(bus0.slave));
   mem_arbiter #(.WAIT_CYCLES(0), .RR_ENABLE(1'b0)) u1 (.clk(clk), .reset_n(rst_n),  .bus(bus1.slave));
   mem_arbiter #(.WAIT_CYCLES(3), .RR_ENABLE(1'b1)) u2 (.clk(clk), .reset_n(rst_n),  .bus(bus2.slave));
   mem_arbiter #(.WAIT_CYCLES(2), .RR_ENABLE(1'b1)) u3 (.clk(clk), .reset_n(rst3_n), .bus(bus3.slave));

   logic [31:0] ram0 [64];
   logic [31:0] ram1 [64];
   logic [31:0] ram2 [64];
   logic [31:0] ram3 [64];

   assign bus0.mem_rd = ram0[bus0.mem_a[7:2]];
   assign bus1.mem_rd = ram1[bus1.mem_a[7:2]];
   assign bus2.mem_rd = ram2[bus2.mem_a[7:2]];
   assign bus3.mem_rd = ram3[bus3.mem_a[7:2]];

   always @(posedge clk) begin
      if (bus0.mem_we) ram0[bus0.mem_a[7:2]] <= bus0.mem_wd;
      if (bus1.mem_we) ram1[bus1.mem_a[7:2]] <= bus1.mem_wd;
      if (bus2.mem_we) ram2[bus2.mem_a[7:2]] <= bus2.mem_wd;
      if (bus3.mem_we) ram3[bus3.mem_a[7:2]] <= bus3.mem_wd;
   end

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One full transaction on bus0; entered and left at posedge+1 in IDLE.
   task automatic txn0(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.is_d) begin
         bus0.d_req = 1'b1; bus0.d_we = v.we; bus0.d_addr = v.addr; bus0.d_wdata = v.wdata;
      end else begin
         bus0.i_req = 1'b1; bus0.i_addr = v.addr;
      end
      @(negedge clk);
      chk({nm, " i_gnt c0"}, bus0.i_gnt, !v.is_d);
      chk({nm, " d_gnt c0"}, bus0.d_gnt, v.is_d);
      @(posedge clk); #1;
      // Changes after the grant must be ignored.
      bus0.i_req = 1'b0; bus0.d_req = 1'b0;
      bus0.i_addr = 32'hFFFF_FFF0; bus0.d_addr = 32'hFFFF_FFF0; bus0.d_wdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk({nm, " mem_we c1"}, bus0.mem_we, v.we);
      chk({nm, " mem_a c1"},  bus0.mem_a,  v.addr);
      if (v.we) chk({nm, " mem_wd c1"}, bus0.mem_wd, v.wdata);
      @(negedge clk);
      chk({nm, " mem_we c2"}, bus0.mem_we, 1'b0);
      if (v.is_d) begin
         chk({nm, " d_rvalid c2"}, bus0.d_rvalid, 1'b1);
         chk({nm, " i_rvalid c2"}, bus0.i_rvalid, 1'b0);
         chk({nm, " d_rdata"},     bus0.d_rdata,  v.exp);
      end else begin
         chk({nm, " i_rvalid c2"}, bus0.i_rvalid, 1'b1);
         chk({nm, " d_rvalid c2"}, bus0.d_rvalid, 1'b0);
         chk({nm, " i_rdata"},     bus0.i_rdata,  v.exp);
      end
      @(negedge clk);
      chk({nm, " rvalid c3"}, {bus0.i_rvalid, bus0.d_rvalid}, 2'b00);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678,  32'hA5A5_0004};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,          32'h1111_0001};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_000F, 32'h0,          32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D,  32'hDEAD_BEEF};
      vecs[6] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,          32'hCAFE_F00D};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'h1234_5678};

      for (int k = 0; k < 64; k++) begin
         ram0[k] = 32'h0; ram1[k] = 32'h0; ram2[k] = 32'h0; ram3[k] = 32'h0;
      end
      ram0[1] = 32'h1111_0001;
      ram0[3] = 32'hDEAD_BEEF;
      ram0[4] = 32'hA5A5_0004;
      ram2[1] = 32'h0BAD_F00D;
      ram3[2] = 32'h5555_AAAA;

      rst_n = 1'b0; rst3_n = 1'b0;
      bus2.i_req = 1'b0; bus2.i_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
      bus2.d_addr = '0; bus2.d_wdata = '0;
      bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
      bus3.d_addr = '0; bus3.d_wdata = '0;
      // Both requesters held high from reset on bus0 and bus1.
      bus0.i_req = 1'b1; bus0.i_addr = 32'h4; bus0.d_req = 1'b1; bus0.d_we = 1'b0;
      bus0.d_addr = 32'hC; bus0.d_wdata = '0;
      bus1.i_req = 1'b1; bus1.i_addr = 32'h4; bus1.d_req = 1'b1; bus1.d_we = 1'b0;
      bus1.d_addr = 32'hC; bus1.d_wdata = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst i_gnt",    bus0.i_gnt,    1'b0);
      chk("rst d_gnt",    bus0.d_gnt,    1'b0);
      chk("rst i_rvalid", bus0.i_rvalid, 1'b0);
      chk("rst d_rvalid", bus0.d_rvalid, 1'b0);
      chk("rst i_rdata",  bus0.i_rdata,  32'h0);
      chk("rst d_rdata",  bus0.d_rdata,  32'h0);
      chk("rst mem_we",   bus0.mem_we,   1'b0);
      chk("rst mem_a",    bus0.mem_a,    32'h0);
      chk("rst mem_wd",   bus0.mem_wd,   32'h0);

      rst_n = 1'b1; rst3_n = 1'b1;
      // Conflict: RR alternates I,D starting with I; fixed priority starves I.
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("rr i_gnt c%0d", c),    bus0.i_gnt,    (c % 6) == 0);
         chk($sformatf("rr d_gnt c%0d", c),    bus0.d_gnt,    (c % 6) == 3);
         chk($sformatf("rr i_rvalid c%0d", c), bus0.i_rvalid, (c % 6) == 2);
         chk($sformatf("rr d_rvalid c%0d", c), bus0.d_rvalid, (c % 6) == 5);
         chk($sformatf("fp i_gnt c%0d", c),    bus1.i_gnt,    1'b0);
         chk($sformatf("fp d_gnt c%0d", c),    bus1.d_gnt,    (c % 3) == 0);
         chk($sformatf("fp i_rvalid c%0d", c), bus1.i_rvalid, 1'b0);
         chk($sformatf("fp d_rvalid c%0d", c), bus1.d_rvalid, (c % 3) == 2);
      end
      chk("rr i_rdata", bus0.i_rdata, 32'h1111_0001);
      chk("rr d_rdata", bus0.d_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      bus0.i_req = 1'b0; bus0.d_req = 1'b0; bus1.i_req = 1'b0; bus1.d_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Back-to-back fetches: one grant every third cycle.
      bus0.i_req = 1'b1; bus0.i_addr = 32'h4;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk($sformatf("b2b i_gnt c%0d", c), bus0.i_gnt, (c % 3) == 0);
         chk($sformatf("b2b d_gnt c%0d", c), bus0.d_gnt, 1'b0);
      end
      @(posedge clk); #1;
      bus0.i_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      for (int v = 0; v < 8; v++) txn0(vecs[v], v);
      chk("i_rdata held", bus0.i_rdata, 32'hCAFE_F00D);

      // Wait states: WAIT=3 fetch.
      bus2.i_req = 1'b1; bus2.i_addr = 32'h4;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("ws i_gnt c%0d", c),    bus2.i_gnt,    c == 0);
         chk($sformatf("ws i_rvalid c%0d", c), bus2.i_rvalid, c == 5);
         chk($sformatf("ws mem_we c%0d", c),   bus2.mem_we,   1'b0);
         if (c >= 1 && c <= 4) chk($sformatf("ws mem_a c%0d", c), bus2.mem_a, 32'h4);
         if (c == 5) chk("ws i_rdata", bus2.i_rdata, 32'h0BAD_F00D);
         if (c == 0) begin
            @(posedge clk); #1;
            bus2.i_req = 1'b0; bus2.i_addr = 32'h0;
         end
      end

      // Reset in the middle of a WAIT=2 store.
      @(posedge clk); #1;
      bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 32'h8; bus3.d_wdata = 32'h7777_0000;
      @(negedge clk);
      chk("rm d_gnt", bus3.d_gnt, 1'b1);
      @(posedge clk); #1;
      bus3.d_req = 1'b0; bus3.d_we = 1'b0;
      @(posedge clk); #1;
      rst3_n = 1'b0;
      #1;
      chk("rm mem_a",   bus3.mem_a,   32'h0);
      chk("rm mem_wd",  bus3.mem_wd,  32'h0);
      chk("rm d_rdata", bus3.d_rdata, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rm mem_we c%0d", c),   bus3.mem_we,   1'b0);
         chk($sformatf("rm d_rvalid c%0d", c), bus3.d_rvalid, 1'b0);
      end
      chk("rm ram untouched", ram3[2], 32'h5555_AAAA);
      @(posedge clk); #1;
      rst3_n = 1'b1;
      @(posedge clk); #1;
      bus3.d_req = 1'b1; bus3.d_addr = 32'h8;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("rm2 d_gnt c%0d", c),    bus3.d_gnt,    c == 0);
         chk($sformatf("rm2 d_rvalid c%0d", c), bus3.d_rvalid, c == 4);
         if (c == 4) chk("rm2 d_rdata", bus3.d_rdata, 32'h5555_AAAA);
         if (c == 0) begin
            @(posedge clk); #1;
            bus3.d_req = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
